// File: rtl/alu_arbiter.sv
// Shared-ALU front end: two requesters compete for one combinational ALU.
// The winner's result is registered with its requester ID and offered on a
// single response channel with backpressure. Per-port grant counters wrap.

module alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] sel,
  output logic [7:0] result,
  output logic       carry
);

  logic [4:0] wide;

  // Opcode decode; sub reports borrow on the carry output.
  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    wide   = 5'd0;
    case (sel)
      3'b000: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = {4'h0, wide[3:0]};
        carry  = wide[4];
      end
      3'b001: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = {4'h0, wide[3:0]};
        carry  = wide[4];
      end
      3'b010: result = {4'h0, a} * {4'h0, b};
      3'b100: result = {4'h0, a & b};
      3'b111: result = {4'h0, a ^ b};
      default: result = {a, b};
    endcase
  end

endmodule

module alu_arbiter #(
  parameter bit FAIR  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_id,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  // Requester that wins a tie; stays 0 in fixed-priority mode.
  logic       prio;
  logic       can_accept;
  logic       grant0;
  logic       grant1;
  logic       accept0;
  logic       accept1;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_carry;

  // Grant, ready and operand steering; readys are masked during reset so no
  // handshake completes on a reset edge.
  always_comb begin
    can_accept = !rsp_valid | rsp_ready;
    grant0     = req0_valid & (!req1_valid | !prio);
    grant1     = req1_valid & (!req0_valid | prio);
    req0_ready = !rst & can_accept & grant0;
    req1_ready = !rst & can_accept & grant1;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
    alu_a      = grant1 ? req1_a   : req0_a;
    alu_b      = grant1 ? req1_b   : req0_b;
    alu_sel    = grant1 ? req1_sel : req0_sel;
  end

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (alu_sel),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Response register, priority pointer and grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_id     <= 1'b0;
      prio       <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept0 | accept1) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_result;
      rsp_carry <= alu_carry;
      rsp_id    <= accept1;
      prio      <= FAIR ? accept0 : 1'b0;
      if (accept0) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (accept1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (round-robin/16-bit counters and
// fixed-priority/4-bit counters) share stimulus; one is observed at a time.
// Expected responses are queued at acceptance and popped by a monitor.

module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       use_fix = 1'b0;
  logic       v0 = 0, v1 = 0, rr = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [2:0] s0 = 0, s1 = 0;

  logic        m_r0, m_r1, m_rv, m_rc, m_id;
  logic [7:0]  m_rd;
  logic [15:0] m_c0, m_c1;
  logic        f_r0, f_r1, f_rv, f_rc, f_id;
  logic [7:0]  f_rd;
  logic [3:0]  f_c0, f_c1;

  alu_arbiter #(.FAIR(1'b1), .CNT_W(16)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(m_r0), .req0_a(a0), .req0_b(b0), .req0_sel(s0),
    .req1_valid(v1), .req1_ready(m_r1), .req1_a(a1), .req1_b(b1), .req1_sel(s1),
    .rsp_valid(m_rv), .rsp_ready(rr), .rsp_data(m_rd), .rsp_carry(m_rc), .rsp_id(m_id),
    .grant_cnt0(m_c0), .grant_cnt1(m_c1)
  );

  alu_arbiter #(.FAIR(1'b0), .CNT_W(4)) dut_fix (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(f_r0), .req0_a(a0), .req0_b(b0), .req0_sel(s0),
    .req1_valid(v1), .req1_ready(f_r1), .req1_a(a1), .req1_b(b1), .req1_sel(s1),
    .rsp_valid(f_rv), .rsp_ready(rr), .rsp_data(f_rd), .rsp_carry(f_rc), .rsp_id(f_id),
    .grant_cnt0(f_c0), .grant_cnt1(f_c1)
  );

  logic        r0, r1, rv, rc, rid;
  logic [7:0]  rd;
  logic [15:0] c0, c1;
  always_comb begin
    r0  = use_fix ? f_r0 : m_r0;
    r1  = use_fix ? f_r1 : m_r1;
    rv  = use_fix ? f_rv : m_rv;
    rc  = use_fix ? f_rc : m_rc;
    rid = use_fix ? f_id : m_id;
    rd  = use_fix ? f_rd : m_rd;
    c0  = use_fix ? {12'h000, f_c0} : m_c0;
    c1  = use_fix ? {12'h000, f_c1} : m_c1;
  end

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       carry;
  } rsp_t;

  rsp_t sb[$];
  rsp_t pending;
  bit   pending_v = 0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: who won last, whether a response is held, counts.
  int last_win = 1;
  bit m_full = 0;
  int cnt0 = 0, cnt1 = 0;
  int last_w = -1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic rsp_t model_rsp(input int id, input int a, input int b, input int sel);
    rsp_t r;
    int   res;
    int   cy;
    cy = 0;
    case (sel)
      0: begin res = a + b; cy = res / 16; res = res % 16; end
      1: begin res = (a - b + 16) % 16; cy = (a < b) ? 1 : 0; end
      2: res = a * b;
      4: res = a & b;
      7: res = a ^ b;
      default: res = a * 16 + b;
    endcase
    r.id    = id[0];
    r.data  = res[7:0];
    r.carry = cy[0];
    return r;
  endfunction

  function automatic int cnt_mod();
    return use_fix ? 16 : 65536;
  endfunction

  // Monitor: every held response must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rv) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          check("rsp_id", int'(rid), int'(sb[0].id));
          check("rsp_data", int'(rd), int'(sb[0].data));
          check("rsp_carry", int'(rc), int'(sb[0].carry));
          if (rr) void'(sb.pop_front());
        end
      end else begin
        check("rsp_missing", sb.size(), 0);
      end
    end
  end

  task automatic cycle(input logic iv0, input logic [3:0] ia0, input logic [3:0] ib0,
                       input logic [2:0] is0, input logic iv1, input logic [3:0] ia1,
                       input logic [3:0] ib1, input logic [2:0] is1, input logic irr);
    int  w;
    bit  can;
    @(posedge clk);
    #1;
    if (pending_v) begin
      sb.push_back(pending);
      pending_v = 0;
    end
    check("grant_cnt0", int'(c0), cnt0);
    check("grant_cnt1", int'(c1), cnt1);
    v0 = iv0; a0 = ia0; b0 = ib0; s0 = is0;
    v1 = iv1; a1 = ia1; b1 = ib1; s1 = is1;
    rr = irr;
    #1;
    can = !m_full || irr;
    w = -1;
    if (iv0 && iv1) w = use_fix ? 0 : (last_win == 0 ? 1 : 0);
    else if (iv0) w = 0;
    else if (iv1) w = 1;
    if (!can) w = -1;
    check("req0_ready", int'(r0), (w == 0) ? 1 : 0);
    check("req1_ready", int'(r1), (w == 1) ? 1 : 0);
    if (w == 0) begin
      pending = model_rsp(0, int'(ia0), int'(ib0), int'(is0));
      pending_v = 1;
      cnt0 = (cnt0 + 1) % cnt_mod();
    end else if (w == 1) begin
      pending = model_rsp(1, int'(ia1), int'(ib1), int'(is1));
      pending_v = 1;
      cnt1 = (cnt1 + 1) % cnt_mod();
    end
    if (w >= 0) begin
      last_win = w;
      m_full = 1;
    end else if (irr) begin
      m_full = 0;
    end
    last_w = w;
  endtask

  task automatic idle(input logic irr);
    cycle(0, 4'h0, 4'h0, 3'h0, 0, 4'h0, 4'h0, 3'h0, irr);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    v0 = 1; a0 = 4'h3; b0 = 4'h2; s0 = 3'h0;
    v1 = 1; a1 = 4'h7; b1 = 4'h1; s1 = 3'h1;
    #1;
    check("rst_ready0", int'(r0), 0);
    check("rst_ready1", int'(r1), 0);
    sb.delete();
    pending_v = 0;
    m_full = 0;
    last_win = 1;
    cnt0 = 0;
    cnt1 = 0;
    @(posedge clk);
    #1;
    rst = 0;
    v0 = 0;
    v1 = 0;
    check("post_rst_valid", int'(rv), 0);
    check("post_rst_cnt0", int'(c0), 0);
    check("post_rst_cnt1", int'(c1), 0);
  endtask

  logic [3:0] ra0, rb0, ra1, rb1;
  logic [2:0] rs0, rs1;
  logic       rv0, rv1;

  task automatic random_run(input int n);
    logic ready_rsp;
    rv0 = 0; rv1 = 0;
    ra0 = 0; rb0 = 0; rs0 = 0; ra1 = 0; rb1 = 0; rs1 = 0;
    for (int i = 0; i < n; i++) begin
      if (!(rv0 && last_w != 0)) begin
        rv0 = ($urandom_range(3) != 0);
        ra0 = 4'($urandom); rb0 = 4'($urandom); rs0 = 3'($urandom);
      end else if ($urandom_range(7) == 0) begin
        rv0 = 0;
      end
      if (!(rv1 && last_w != 1)) begin
        rv1 = ($urandom_range(3) != 0);
        ra1 = 4'($urandom); rb1 = 4'($urandom); rs1 = 3'($urandom);
      end else if ($urandom_range(7) == 0) begin
        rv1 = 0;
      end
      ready_rsp = ($urandom_range(3) != 0);
      cycle(rv0, ra0, rb0, rs0, rv1, ra1, rb1, rs1, ready_rsp);
    end
    idle(1);
    idle(1);
  endtask

  logic [7:0] held_data;
  logic       held_id;

  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    do_reset();

    // Single add from port 0
    cycle(1, 4'd10, 4'd5, 3'b000, 0, 4'h0, 4'h0, 3'h0, 1);
    idle(1);
    check("add_data", int'(rd), 8'h0F);
    check("add_carry", int'(rc), 0);
    check("add_id", int'(rid), 0);
    check("add_cnt0", int'(c0), 1);

    // Back-to-back from port 1
    cycle(0, 4'h0, 4'h0, 3'h0, 1, 4'd15, 4'd5, 3'b001, 1);
    cycle(0, 4'h0, 4'h0, 3'h0, 1, 4'd3, 4'd4, 3'b010, 1);
    check("sub_data", int'(rd), 8'h0A);
    idle(1);
    check("mul_data", int'(rd), 8'h0C);
    check("mul_id", int'(rid), 1);
    idle(1);

    // Both ports valid, round-robin alternation
    for (int i = 0; i < 4; i++) begin
      cycle(1, 4'b1010, 4'b1100, 3'b100, 1, 4'b1010, 4'b1100, 3'b111, 1);
      check("rr_winner", last_w, i % 2);
    end
    idle(1);
    idle(1);

    // Backpressure: response held for 3 cycles, then drain+accept together
    cycle(1, 4'd6, 4'd7, 3'b000, 0, 4'h0, 4'h0, 3'h0, 1);
    cycle(1, 4'd2, 4'd9, 3'b010, 1, 4'd8, 4'd3, 3'b001, 0);
    held_data = rd;
    held_id = rid;
    cycle(1, 4'd2, 4'd9, 3'b010, 1, 4'd8, 4'd3, 3'b001, 0);
    cycle(1, 4'd2, 4'd9, 3'b010, 1, 4'd8, 4'd3, 3'b001, 0);
    check("stall_data", int'(rd), int'(held_data));
    check("stall_id", int'(rid), int'(held_id));
    check("stall_ready0", int'(r0), 0);
    check("stall_ready1", int'(r1), 0);
    cycle(1, 4'd2, 4'd9, 3'b010, 1, 4'd8, 4'd3, 3'b001, 1);
    check("release_accept", (last_w >= 0) ? 1 : 0, 1);
    idle(1);
    idle(1);

    // Reset while a response is held and both ports are valid
    cycle(1, 4'd1, 4'd1, 3'b000, 1, 4'd2, 4'd2, 3'b000, 0);
    cycle(1, 4'd3, 4'd1, 3'b000, 1, 4'd2, 4'd2, 3'b000, 0);
    do_reset();
    cycle(1, 4'd5, 4'd5, 3'b111, 1, 4'd9, 4'd1, 3'b000, 1);
    check("post_rst_first_grant", last_w, 0);
    idle(1);

    random_run(400);

    // Fixed-priority instance with 4-bit counters
    use_fix = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 4'b1010, 4'b1100, 3'b100, 1, 4'b1010, 4'b1100, 3'b111, 1);
      check("fix_winner", last_w, 0);
    end
    while (cnt0 != 15) cycle(1, 4'd4, 4'd3, 3'b000, 0, 4'h0, 4'h0, 3'h0, 1);
    idle(1);
    check("cnt0_max", int'(c0), 15);
    cycle(1, 4'd4, 4'd3, 3'b000, 0, 4'h0, 4'h0, 3'h0, 1);
    idle(1);
    check("cnt0_wrap", int'(c0), 0);

    random_run(400);

    idle(1);
    idle(1);
    check("sb_drained", sb.size() + (pending_v ? 1 : 0), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and result buffer that shares one combinational `alu` instance between two independent requesters. Each requester presents operands and an opcode with a valid/ready handshake. The arbiter grants one request per cycle, registers the `alu` result together with the requester ID, and returns it on a single response channel with backpressure. It sits between the instruction-issue logic and the shared ALU datapath.

## Interface
- `FAIR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, with requester 0 always winning.
- `CNT_W`, default 16: width of the per-requester grant counters.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req0_valid`, `req1_valid`  in  1 each  request presented.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle when valid is also high.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  4 each  operands.
- `req0_sel`, `req1_sel`  in  3 each  opcode, passed unchanged to the `alu` select input.
- `rsp_valid`  out  1  response held in the output register.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  8  registered result from the `alu` result output.
- `rsp_carry`  out  1  registered carry from the `alu` carry output.
- `rsp_id`  out  1  ID of the requester that owns the response.
- `grant_cnt0`, `grant_cnt1`  out  CNT_W each  number of accepted requests per port.

## Operation
- Instantiates `alu`, a combinational unit with 4-bit A and B, a 3-bit select, an 8-bit result and a carry output. Opcodes relied on by the tests:
  - 000 add
  - 001 sub
  - 010 mul
  - 100 and
  - 111 xor
- Other opcodes pass through unchanged; the arbiter never decodes them.
- `can_accept = !rsp_valid | rsp_ready`.
- Priority pointer `prio` (1 bit):
  - When both requesters are valid, requester `prio` wins.
  - When only one is valid, that one wins.
- Ready and operand steering:
  - `reqN_ready = can_accept & grant_N`. Ready depends combinationally on the valid inputs.
  - The granted requester's operands and opcode drive the `alu` inputs.
  - When nothing is granted, the requester-0 inputs drive the `alu`. The result is don't-care in that case.
- On accept (valid & ready on port N):
  - Capture `rsp_data` and `rsp_carry` from the `alu` outputs.
  - `rsp_id <= N`, `rsp_valid <= 1`.
  - `grant_cntN` increments.
  - If `FAIR=1`: `prio <= ~N`. If `FAIR=0`: `prio` stays 0.
- Response drain:
  - If `rsp_valid & rsp_ready` and there is no new accept, `rsp_valid <= 0`.
  - Drain and a new accept in the same cycle: the new result replaces the old one and `rsp_valid` stays 1.
- Hold rule: while `rsp_valid & !rsp_ready`, both readys are 0 and `rsp_*` stays stable.
- Requester rule: a requester must hold its operands and opcode stable while valid is high and not yet accepted. Valid may drop without acceptance.
- Counters wrap at 2^CNT_W − 1 → 0 with no saturation.
- State machine, implicit in `rsp_valid`:
  - EMPTY (`rsp_valid=0`): goes to FULL on any accept.
  - FULL (`rsp_valid=1`): goes to EMPTY on drain with no accept; stays FULL on drain+accept or on stall.

## Timing
- Reset values:
  - `rsp_valid=0`, `rsp_data=0`, `rsp_carry=0`, `rsp_id=0`
  - `prio=0`, `grant_cnt0=0`, `grant_cnt1=0`
  - `req0_ready`/`req1_ready` follow the combinational rule, so `req0_ready=1` when `req0_valid=1` in the first cycle after reset.
- Latency: a request accepted in cycle N shows `rsp_valid=1` in cycle N+1 with its result.
- Throughput: one request per cycle while `rsp_ready` is held high.
- Round-robin with both ports continuously valid: grants alternate 0,1,0,1… starting with port 0 after reset.
- Reset asserted mid-operation:
  - Any pending response is discarded.
  - Counters and `prio` clear on the next edge.
  - No ready is honoured in a cycle where `rst=1`; readys are forced to 0.

## Test plan
- Port 0 issues A=10, B=5, sel=000 with `rsp_ready=1` → one cycle later `rsp_data=0x0F`, `rsp_carry=0`, `rsp_id=0`, `grant_cnt0=1`.
- Port 1 issues A=15, B=5, sel=001, then A=3, B=4, sel=010 back-to-back → consecutive responses `0x0A` then `0x0C`, both with `rsp_id=1`.
- Both ports valid for 4 cycles:
  - Port 0 sends A=1010, B=1100, sel=100; port 1 sends the same operands with sel=111.
  - Required responses in order: `rsp_id` 0,1,0,1 with data `0x08`, `0x06`, `0x08`, `0x06`.
  - Repeat with `FAIR=0`: all four grants go to port 0.
- Backpressure: hold `rsp_ready=0` for 3 cycles after the first response → both readys stay 0 and `rsp_data`/`rsp_id` stay stable. Raise `rsp_ready` → the next request is accepted in the same cycle and its response follows one cycle later.
- Assert `rst` for 1 cycle while `rsp_valid=1` and both ports are valid → the next cycle shows `rsp_valid=0`, both counters 0, and the first grant goes to port 0.
- Force `grant_cnt0` to 0xFFFF and accept one port-0 request → `grant_cnt0=0x0000`.
